// File: rtl/dmem_access_pkg.sv
// dmem_access_pkg: shared funct3 codes, FSM states and byte-enable type for the data-memory access unit
package dmem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef logic [3:0] be_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_access_if.sv
// dmem_access_if: request/response bus between the access unit and data memory
interface dmem_access_if;
    import dmem_access_pkg::*;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    be_t         mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/dmem_access_load_extend.sv
// load_extend: picks the addressed byte/half of a memory word and sign- or zero-extends it
module load_extend
    import dmem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    // Lane select followed by extension chosen by the load type.
    always_comb begin
        b      = rdata_i[{off_i, 3'b000} +: 8];
        h      = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = funct3_i == F3_LB  ? {{24{b[7]}}, b}  :
                 funct3_i == F3_LH  ? {{16{h[15]}}, h} :
                 funct3_i == F3_LBU ? {24'b0, b}       :
                 funct3_i == F3_LHU ? {16'b0, h}       : rdata_i;
    end

endmodule

// File: rtl/dmem_access.sv
// dmem_access: MEM-stage load/store unit with stall, alignment checks and a WAIT timeout
module dmem_access
    import dmem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic [2:0]         funct3_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        MemRdata_o,
    output logic               stall_o,
    output logic               err_o,
    dmem_access_if.master      mem
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        ld_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        access, is_st, legal, bad, timeout;
    be_t         be_d;
    logic [31:0] wdata_d, ext;

    // Decode of the incoming request; a simultaneous read+write is a store.
    always_comb begin
        is_st   = MemWrite_i;
        access  = MemRead_i | MemWrite_i;
        legal   = is_st ? (funct3_i inside {F3_SB, F3_SH, F3_SW})
                        : (funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        bad     = !legal || misaligned(funct3_i, addr_i[1:0]);
        timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
        be_d    = funct3_i[1:0] == 2'b00 ? be_t'(4'b0001 << addr_i[1:0]) :
                  funct3_i[1:0] == 2'b01 ? be_t'(4'b0011 << addr_i[1:0]) : 4'b1111;
        wdata_d = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}}  :
                  funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    end

    load_extend u_ext (
        .rdata_i  (mem.mem_rdata_i),
        .funct3_i (f3_q),
        .off_i    (off_q),
        .data_o   (ext)
    );

    // Next state and stall; the pipeline is frozen from request acceptance until DONE.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_o = access & ~rst_i;
                if (access) state_d = bad ? DONE : WAIT;
            end
            WAIT: begin
                stall_o = ~rst_i;
                if (mem.mem_ack_i || timeout) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request bus, load result, error pulse and WAIT counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            MemRdata_o      <= '0;
            err_o           <= 1'b0;
            cnt_q           <= '0;
            ld_q            <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_be_o    <= '0;
            mem.mem_wdata_o <= '0;
        end else begin
            err_o <= 1'b0;
            unique case (state_q)
                IDLE: if (access) begin
                    ld_q  <= ~is_st;
                    f3_q  <= funct3_i;
                    off_q <= addr_i[1:0];
                    cnt_q <= '0;
                    if (bad) begin
                        err_o <= 1'b1;
                        if (!is_st) MemRdata_o <= '0;
                    end else begin
                        mem.mem_req_o   <= 1'b1;
                        mem.mem_we_o    <= is_st;
                        mem.mem_addr_o  <= {addr_i[31:2], 2'b00};
                        mem.mem_be_o    <= be_d;
                        mem.mem_wdata_o <= wdata_d;
                    end
                end
                WAIT: if (mem.mem_ack_i) begin
                    mem.mem_req_o <= 1'b0;
                    if (ld_q) MemRdata_o <= ext;
                end else if (timeout) begin
                    mem.mem_req_o <= 1'b0;
                    err_o         <= 1'b1;
                    if (ld_q) MemRdata_o <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed scoreboard bench for dmem_access
module tb_dmem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata_out;
    logic        stall, err;
    int          n_chk = 0, n_fail = 0;

    dmem_access_if bus ();

    dmem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (rd),
        .MemWrite_i (wr),
        .funct3_i   (f3),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .MemRdata_o (rdata_out),
        .stall_o    (stall),
        .err_o      (err),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          stalls;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one access from IDLE, ack on WAIT cycle ack_at (0 = never), return in IDLE.
    task automatic acc(input logic r, input logic w, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] mrd, input int ack_at,
                       input logic e_err, input logic [31:0] e_rd, input logic e_req,
                       input logic [3:0] e_be, input logic [31:0] e_wd, input int e_st);
        exp_t e;
        int n;
        e.err = e_err; e.rd = e_rd; e.req = e_req; e.we = w;
        e.addr = {a[31:2], 2'b00}; e.be = e_be; e.wd = e_wd; e.stalls = e_st;
        q.push_back(e);
        rd = r; wr = w; f3 = fn; addr = a; wdata = wd; bus.mem_rdata_i = mrd;
        n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            if (!stall) break;
            if (n > 20) begin
                n_chk++; n_fail++;
                $display("FAIL access_timeout: stall still %b after %0d cycles", stall, n);
                break;
            end
            bus.mem_ack_i = (n == ack_at);
        end
        bus.mem_ack_i = 1'b0;
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: tracks each transaction and scores it when DONE (stall falling) appears.
    initial begin
        logic seen, unst, prev;
        int st_cnt, er_cnt;
        logic [31:0] c_addr, c_wd;
        logic [3:0]  c_be;
        logic        c_we;
        exp_t e;
        seen = 0; unst = 0; prev = 0; st_cnt = 0; er_cnt = 0;
        c_addr = '0; c_wd = '0; c_be = '0; c_we = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0; unst = 0; prev = 0; st_cnt = 0; er_cnt = 0;
            end else begin
                if (stall) st_cnt++;
                if (err) er_cnt++;
                if (bus.mem_req_o) begin
                    if (!seen) begin
                        seen = 1; c_we = bus.mem_we_o; c_addr = bus.mem_addr_o;
                        c_be = bus.mem_be_o; c_wd = bus.mem_wdata_o;
                    end else if ({c_we, c_addr, c_be, c_wd} !== {bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o})
                        unst = 1;
                end
                if (prev && !stall) begin
                    if (q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_done: no transaction queued");
                    end else begin
                        e = q.pop_front();
                        chk("rdata", rdata_out, e.rd);
                        chk("err_pulses", er_cnt, {31'b0, e.err});
                        chk("req_issued", {31'b0, seen}, {31'b0, e.req});
                        chk("stall_cycles", st_cnt, e.stalls);
                        chk("bus_stable", {31'b0, unst}, 32'd0);
                        if (e.req) begin
                            chk("mem_we", {31'b0, c_we}, {31'b0, e.we});
                            chk("mem_addr", c_addr, e.addr);
                            if (e.we) begin
                                chk("mem_be", {28'b0, c_be}, {28'b0, e.be});
                                chk("mem_wdata", c_wd, e.wd);
                            end
                        end
                    end
                    seen = 0; unst = 0; st_cnt = 0; er_cnt = 0;
                end
                prev = stall;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_req", {31'b0, bus.mem_req_o}, 32'd0);
        chk("rst_we", {31'b0, bus.mem_we_o}, 32'd0);
        chk("rst_be", {28'b0, bus.mem_be_o}, 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        //  r  w  f3      addr          wdata         mem_rdata    ack err rdata         req be       wdata        stalls
        acc(1, 0, 3'b000, 32'h103,      32'h0,        32'h80FF1234, 1, 0, 32'hFFFFFF80, 1, 4'b0000, 32'h0,        2);
        acc(1, 0, 3'b101, 32'h102,      32'h0,        32'h9ABC0000, 1, 0, 32'h00009ABC, 1, 4'b0000, 32'h0,        2);
        acc(0, 1, 3'b001, 32'h102,      32'h0000BEEF, 32'h0,        2, 0, 32'h00009ABC, 1, 4'b1100, 32'hBEEFBEEF, 3);
        acc(1, 0, 3'b010, 32'h101,      32'h0,        32'h0,        1, 1, 32'h0,        0, 4'b0000, 32'h0,        1);
        acc(1, 0, 3'b010, 32'h200,      32'h0,        32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 1, 4'b0000, 32'h0,        2);
        acc(1, 0, 3'b001, 32'h202,      32'h0,        32'h80010000, 1, 0, 32'hFFFF8001, 1, 4'b0000, 32'h0,        2);
        acc(1, 0, 3'b100, 32'h201,      32'h0,        32'h0000A500, 3, 0, 32'h000000A5, 1, 4'b0000, 32'h0,        4);
        acc(0, 1, 3'b000, 32'h303,      32'h12345678, 32'h0,        1, 0, 32'h000000A5, 1, 4'b1000, 32'h78787878, 2);
        acc(0, 1, 3'b010, 32'h304,      32'hCAFEF00D, 32'h0,        1, 0, 32'h000000A5, 1, 4'b1111, 32'hCAFEF00D, 2);
        acc(1, 0, 3'b011, 32'h0,        32'h0,        32'h0,        1, 1, 32'h0,        0, 4'b0000, 32'h0,        1);
        acc(1, 0, 3'b000, 32'h0,        32'h0,        32'h0000007F, 1, 0, 32'h0000007F, 1, 4'b0000, 32'h0,        2);
        acc(0, 1, 3'b100, 32'h0,        32'h55,       32'h0,        1, 1, 32'h0000007F, 0, 4'b0000, 32'h0,        1);
        acc(0, 1, 3'b001, 32'h101,      32'hAAAA,     32'h0,        1, 1, 32'h0000007F, 0, 4'b0000, 32'h0,        1);
        acc(1, 1, 3'b010, 32'h10,       32'h11223344, 32'hFFFFFFFF, 1, 0, 32'h0000007F, 1, 4'b1111, 32'h11223344, 2);
        acc(1, 0, 3'b010, 32'h40,       32'h0,        32'h0,        0, 1, 32'h0,        1, 4'b0000, 32'h0,        5);
        acc(1, 0, 3'b000, 32'h42,       32'h0,        32'h00330000, 4, 0, 32'h00000033, 1, 4'b0000, 32'h0,        5);

        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ack_stall", {31'b0, stall}, 32'd0);
        chk("idle_ack_req", {31'b0, bus.mem_req_o}, 32'd0);
        chk("idle_ack_rdata", rdata_out, 32'h00000033);
        bus.mem_ack_i = 1'b0;

        rd = 1'b1; f3 = 3'b010; addr = 32'h50;
        @(posedge clk); #1;
        chk("rst_wait1_req", {31'b0, bus.mem_req_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
        #1 chk("rst_stall_low", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_ack_i = 1'b0; rd = 1'b0;
        chk("rst_abort_req", {31'b0, bus.mem_req_o}, 32'd0);
        chk("rst_abort_rdata", rdata_out, 32'h0);
        chk("rst_abort_stall", {31'b0, stall}, 32'd0);
        chk("rst_abort_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_req", {31'b0, bus.mem_req_o}, 32'd0);

        repeat (2) @(posedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
